// File: rtl/bram_arb2_if.sv
// bram_arb2_if: bundles the two client request/response channels and the
// simple-dual-port BRAM pins that bram_arb2 sits between.
interface bram_arb2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 7
);
  // client 0
  logic                  m0_req;
  logic                  m0_we;
  logic [AW-1:0]         m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata;
  // client 1
  logic                  m1_req;
  logic                  m1_we;
  logic [AW-1:0]         m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_WIDTH-1:0] m1_rdata;
  // BRAM port A (write) / port B (read)
  logic                  bram_wea;
  logic                  bram_ena;
  logic [AW-1:0]         bram_addra;
  logic [DATA_WIDTH-1:0] bram_dina;
  logic                  bram_enb;
  logic [AW-1:0]         bram_addrb;
  logic [DATA_WIDTH-1:0] bram_doutb;

  // arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output bram_wea, bram_ena, bram_addra, bram_dina,
    output bram_enb, bram_addrb,
    input  bram_doutb
  );

  // client side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata
  );

  // BRAM side
  modport mem (
    input  bram_wea, bram_ena, bram_addra, bram_dina,
    input  bram_enb, bram_addrb,
    output bram_doutb
  );
endinterface

// File: rtl/bram_arb2.sv
// bram_arb2: two-client arbiter for one simple dual-port BRAM.
// Write port and read port have independent round-robin pointers, so one
// write and one read can be granted in the same cycle. Read data is routed
// back to its issuer by an {valid,id} pipeline LATENCY stages deep.
// Optional: define BRAM_ARB_PERF_CNT_EN to add saturating per-port
// conflict counters (wr_conflict_cnt / rd_conflict_cnt).
module bram_arb2 #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 128,
  parameter int LATENCY    = 1,
  localparam int AW        = $clog2(SIZE)
) (
  input  logic       clk,
  input  logic       rst,
  bram_arb2_if.slave bus
`ifdef BRAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0] wr_conflict_cnt,
  output logic [31:0] rd_conflict_cnt
`endif
);

  logic [1:0]                 w_req, w_we;
  logic [1:0][AW-1:0]         w_addr;
  logic [1:0][DATA_WIDTH-1:0] w_wdata;

  assign w_req   = {bus.m1_req,   bus.m0_req};
  assign w_we    = {bus.m1_we,    bus.m0_we};
  assign w_addr  = {bus.m1_addr,  bus.m0_addr};
  assign w_wdata = {bus.m1_wdata, bus.m0_wdata};

  logic r_wr_ptr, r_rd_ptr;

  // Candidates are masked during reset so no grant or enable leaks out.
  logic [1:0] w_wcand, w_rcand;
  assign w_wcand = w_req &  w_we & {2{~rst}};
  assign w_rcand = w_req & ~w_we & {2{~rst}};

  logic w_wboth, w_rboth, w_wgnt, w_rgnt, w_wid, w_rid;
  assign w_wboth = &w_wcand;
  assign w_rboth = &w_rcand;
  assign w_wgnt  = |w_wcand;
  assign w_rgnt  = |w_rcand;
  // Lone requester wins outright; on a tie the pointer picks.
  assign w_wid   = w_wboth ? r_wr_ptr : w_wcand[1];
  assign w_rid   = w_rboth ? r_rd_ptr : w_rcand[1];

  assign bus.m0_gnt = (w_wgnt & ~w_wid) | (w_rgnt & ~w_rid);
  assign bus.m1_gnt = (w_wgnt &  w_wid) | (w_rgnt &  w_rid);

  assign bus.bram_wea   = w_wgnt;
  assign bus.bram_ena   = w_wgnt;
  assign bus.bram_addra = w_wgnt ? w_addr[w_wid]  : '0;
  assign bus.bram_dina  = w_wgnt ? w_wdata[w_wid] : '0;
  assign bus.bram_enb   = w_rgnt;
  assign bus.bram_addrb = w_rgnt ? w_addr[w_rid]  : '0;

  // Round-robin pointers: only a contended grant hands priority to the loser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_wboth) r_wr_ptr <= ~w_wid;
      if (w_rboth) r_rd_ptr <= ~w_rid;
    end
  end

  logic [LATENCY-1:0] r_vld_pipe, r_id_pipe;

  // Read tag pipeline, aligned with the BRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe[0] <= w_rgnt;
      r_id_pipe[0]  <= w_rid;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_id_pipe[i]  <= r_id_pipe[i-1];
      end
    end
  end

  logic w_rv0, w_rv1;
  assign w_rv0 = r_vld_pipe[LATENCY-1] & ~r_id_pipe[LATENCY-1];
  assign w_rv1 = r_vld_pipe[LATENCY-1] &  r_id_pipe[LATENCY-1];

  assign bus.m0_rvalid = w_rv0;
  assign bus.m1_rvalid = w_rv1;
  assign bus.m0_rdata  = w_rv0 ? bus.bram_doutb : '0;
  assign bus.m1_rdata  = w_rv1 ? bus.bram_doutb : '0;

`ifdef BRAM_ARB_PERF_CNT_EN
  logic w_wconf, w_rconf;
  assign w_wconf = &(w_req &  w_we);
  assign w_rconf = &(w_req & ~w_we);

  // Saturating count of cycles where both clients contended for a port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_conflict_cnt <= '0;
      rd_conflict_cnt <= '0;
    end else begin
      if (w_wconf && !(&wr_conflict_cnt)) wr_conflict_cnt <= wr_conflict_cnt + 32'd1;
      if (w_rconf && !(&rd_conflict_cnt)) rd_conflict_cnt <= rd_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
